// File: rtl/reg_port_arbiter_if.sv
// Bus bundle between the register-port arbiter, the SPI application side,
// port B and the register bank. The slave modport is the arbiter's view.
interface reg_port_arbiter_if #(
    parameter int unsigned REG_W = 8
);
    // SPI application side
    logic             spi_cs_n;
    logic [REG_W-2:0] spi_addr;
    logic [REG_W-1:0] spi_wdata;
    logic             spi_we;
    logic [REG_W-1:0] spi_rdata;
    logic [REG_W-1:0] spi_status;

    // Port B requester
    logic             b_req;
    logic             b_wr;
    logic [REG_W-2:0] b_addr;
    logic [REG_W-1:0] b_wdata;
    logic             b_ready;
    logic             b_rvalid;
    logic [REG_W-1:0] b_rdata;

    // Register bank
    logic             bank_we;
    logic [REG_W-2:0] bank_waddr;
    logic [REG_W-1:0] bank_wdata;
    logic [REG_W-2:0] bank_raddr;
    logic [REG_W-1:0] bank_rdata;

    modport slave (
        input  spi_cs_n, spi_addr, spi_wdata, spi_we,
        input  b_req, b_wr, b_addr, b_wdata,
        input  bank_rdata,
        output spi_rdata, spi_status,
        output b_ready, b_rvalid, b_rdata,
        output bank_we, bank_waddr, bank_wdata, bank_raddr
    );

    modport master (
        output spi_cs_n, spi_addr, spi_wdata, spi_we,
        output b_req, b_wr, b_addr, b_wdata,
        output bank_rdata,
        input  spi_rdata, spi_status,
        input  b_ready, b_rvalid, b_rdata,
        input  bank_we, bank_waddr, bank_wdata, bank_raddr
    );
endinterface

// File: rtl/reg_port_arbiter.sv
// Shares one register bank between the SPI application interface and port B.
// SPI writes always win; port-B reads borrow the read port only outside SPI
// frames. Also builds the status byte shifted out at the start of each frame.
module reg_port_arbiter #(
    parameter int unsigned REG_W   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input logic               clk,
    input logic               rstb,
    input logic               ena,
    reg_port_arbiter_if.slave bus
);

    if (REG_W < 4) begin : g_bad_width
        $error("reg_port_arbiter: REG_W must be at least 4");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("reg_port_arbiter: TIMEOUT must be in 1..255");
    end

    localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StBRd  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             we_q, we_d;
    logic [REG_W-2:0] waddr_q, waddr_d;
    logic [REG_W-1:0] wdata_q, wdata_d;
    logic [REG_W-2:0] b_addr_q, b_addr_d;
    logic             b_rvalid_q, b_rvalid_d;
    logic [REG_W-1:0] b_rdata_q, b_rdata_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             coll_q, coll_d;
    logic             to_q, to_d;
    logic             cs_prev_q, cs_prev_d;

    logic             b_ready;
    logic             b_accept_wr;
    logic             b_accept_rd;
    logic             b_waiting;
    logic             cs_rise;
    logic             coll_set;
    logic             to_set;
    logic [REG_W-1:0] status;

    // Port-B acceptance and the events feeding the sticky status bits.
    always_comb begin
        b_ready     = ena & (state_q == StIdle) & ~bus.spi_we & (bus.b_wr | bus.spi_cs_n);
        b_accept_wr = bus.b_req & b_ready & bus.b_wr;
        b_accept_rd = bus.b_req & b_ready & ~bus.b_wr;
        b_waiting   = bus.b_req & ~b_ready;
        cs_rise     = bus.spi_cs_n & ~cs_prev_q;
        coll_set    = bus.spi_we & bus.b_req & bus.b_wr;
    end

    // Next-state logic; with ena low every register holds.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        b_addr_d   = b_addr_q;
        b_rvalid_d = b_rvalid_q;
        b_rdata_d  = b_rdata_q;
        cnt_d      = cnt_q;
        coll_d     = coll_q;
        to_d       = to_q;
        cs_prev_d  = cs_prev_q;
        to_set     = 1'b0;

        if (ena) begin
            unique case (state_q)
                StIdle:  state_d = b_accept_rd ? StBRd : StIdle;
                StBRd:   state_d = StIdle;
                default: state_d = StIdle;
            endcase

            // Registered write port: SPI wins over a same-cycle port-B write.
            we_d = bus.spi_we | b_accept_wr;
            if (bus.spi_we) begin
                waddr_d = bus.spi_addr;
                wdata_d = bus.spi_wdata;
            end else if (b_accept_wr) begin
                waddr_d = bus.b_addr;
                wdata_d = bus.b_wdata;
            end

            if (b_accept_rd) begin
                b_addr_d = bus.b_addr;
            end

            // The read completes in B_RD while the bank is addressed by b_addr_q.
            b_rvalid_d = (state_q == StBRd);
            if (state_q == StBRd) begin
                b_rdata_d = bus.bank_rdata;
            end

            // Saturating wait counter for a stalled port-B request.
            if (b_waiting) begin
                cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                to_set = (cnt_d >= TimeoutVal);
            end else begin
                cnt_d = 8'd0;
            end

            // Sticky bits clear on the cs rising edge; a same-cycle set wins.
            coll_d    = coll_set | (coll_q & ~cs_rise);
            to_d      = to_set | (to_q & ~cs_rise);
            cs_prev_d = bus.spi_cs_n;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            b_addr_q   <= '0;
            b_rvalid_q <= 1'b0;
            b_rdata_q  <= '0;
            cnt_q      <= 8'd0;
            coll_q     <= 1'b0;
            to_q       <= 1'b0;
            cs_prev_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            b_addr_q   <= b_addr_d;
            b_rvalid_q <= b_rvalid_d;
            b_rdata_q  <= b_rdata_d;
            cnt_q      <= cnt_d;
            coll_q     <= coll_d;
            to_q       <= to_d;
            cs_prev_q  <= cs_prev_d;
        end
    end

    // Status byte: request pending, collision, timeout, read in progress.
    always_comb begin
        status          = '0;
        status[REG_W-1] = bus.b_req;
        status[REG_W-2] = coll_q;
        status[REG_W-3] = to_q;
        status[REG_W-4] = (state_q == StBRd);
    end

    assign bus.b_ready    = b_ready;
    assign bus.b_rvalid   = b_rvalid_q;
    assign bus.b_rdata    = b_rdata_q;
    assign bus.bank_we    = we_q & ena;
    assign bus.bank_waddr = waddr_q;
    assign bus.bank_wdata = wdata_q;
    assign bus.bank_raddr = (state_q == StBRd) ? b_addr_q : bus.spi_addr;
    assign bus.spi_rdata  = bus.bank_rdata;
    assign bus.spi_status = status;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Directed bench for reg_port_arbiter with a behavioural register bank.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_reg_port_arbiter;

    localparam int unsigned REG_W = 8;

    logic clk = 1'b0;
    logic rstb;
    logic ena;

    always #5 clk = ~clk;

    reg_port_arbiter_if #(.REG_W(REG_W)) bus ();

    reg_port_arbiter #(
        .REG_W  (REG_W),
        .TIMEOUT(255)
    ) dut (
        .clk (clk),
        .rstb(rstb),
        .ena (ena),
        .bus (bus)
    );

    // Register bank: one write port, combinational read port.
    logic [REG_W-1:0] mem [128];
    always @(posedge clk) begin
        if (bus.bank_we) mem[bus.bank_waddr] <= bus.bank_wdata;
    end
    assign bus.bank_rdata = mem[bus.bank_raddr];

    int checks = 0;
    int errors = 0;

    task automatic inputs_quiet();
        bus.spi_we    = 1'b0;
        bus.spi_wdata = '0;
        bus.b_req     = 1'b0;
        bus.b_wr      = 1'b0;
        bus.b_addr    = '0;
        bus.b_wdata   = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstb = 1'b0; bus.spi_cs_n = 1'b1; bus.b_req = 1'b1; bus.b_wr = 1'b0;
        #1;
        checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL rst_b_ready got %b want 1", bus.b_ready); end
        checks++; if (bus.spi_status !== 8'h80) begin errors++; $display("FAIL rst_status got %h want 80", bus.spi_status); end
        checks++; if (bus.bank_we !== 1'b0) begin errors++; $display("FAIL rst_bank_we got %b want 0", bus.bank_we); end
        checks++; if (bus.b_rvalid !== 1'b0 || bus.b_rdata !== 8'h00) begin errors++; $display("FAIL rst_rvalid_rdata got %b/%h want 0/00", bus.b_rvalid, bus.b_rdata); end
        checks++; if (bus.bank_waddr !== 7'h00 || bus.bank_wdata !== 8'h00) begin errors++; $display("FAIL rst_waddr_wdata got %h/%h want 00/00", bus.bank_waddr, bus.bank_wdata); end
        bus.spi_cs_n = 1'b0;
        #1;
        checks++; if (bus.b_ready !== 1'b0) begin errors++; $display("FAIL rst_b_ready_cs_low got %b want 0", bus.b_ready); end
        @(negedge clk);
        rstb = 1'b1; bus.spi_cs_n = 1'b1; inputs_quiet();
        #1;
        checks++; if (bus.spi_status !== 8'h00) begin errors++; $display("FAIL post_rst_status got %h want 00", bus.spi_status); end
    endtask

    task automatic test_spi_write();
        @(negedge clk);
        bus.spi_cs_n = 1'b0; bus.spi_we = 1'b1; bus.spi_addr = 7'h05; bus.spi_wdata = 8'hA5;
        #1;
        checks++; if (bus.bank_we !== 1'b0) begin errors++; $display("FAIL spi_wr_t got %b want 0", bus.bank_we); end
        @(negedge clk);
        bus.spi_we = 1'b0;
        #1;
        checks++; if (bus.bank_we !== 1'b1 || bus.bank_waddr !== 7'h05 || bus.bank_wdata !== 8'hA5) begin errors++; $display("FAIL spi_wr_t1 got %b/%h/%h want 1/05/a5", bus.bank_we, bus.bank_waddr, bus.bank_wdata); end
        @(negedge clk);
        #1;
        checks++; if (bus.bank_we !== 1'b0) begin errors++; $display("FAIL spi_wr_t2 got %b want 0", bus.bank_we); end
    endtask

    task automatic test_spi_read();
        @(negedge clk);
        bus.spi_we = 1'b1; bus.spi_addr = 7'h07; bus.spi_wdata = 8'h5A;
        @(negedge clk);
        bus.spi_we = 1'b1; bus.spi_addr = 7'h10; bus.spi_wdata = 8'h3C;
        @(negedge clk);
        bus.spi_we = 1'b0; bus.spi_addr = 7'h07;
        #1;
        checks++; if (bus.spi_rdata !== 8'h5A || bus.bank_raddr !== 7'h07) begin errors++; $display("FAIL spi_rd got %h@%h want 5a@07", bus.spi_rdata, bus.bank_raddr); end
        @(negedge clk);
        bus.spi_cs_n = 1'b1; bus.spi_addr = 7'h05;
    endtask

    task automatic test_back_to_back_writes();
        @(negedge clk);
        bus.b_req = 1'b1; bus.b_wr = 1'b1; bus.b_addr = 7'h20; bus.b_wdata = 8'h01;
        #1;
        checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got %b want 1", bus.b_ready); end
        @(negedge clk);
        bus.b_addr = 7'h21; bus.b_wdata = 8'h02;
        #1;
        checks++; if (bus.b_ready !== 1'b1 || bus.bank_we !== 1'b1 || bus.bank_waddr !== 7'h20 || bus.bank_wdata !== 8'h01) begin errors++; $display("FAIL b2b_wr0 got %b %b/%h/%h want 1 1/20/01", bus.b_ready, bus.bank_we, bus.bank_waddr, bus.bank_wdata); end
        @(negedge clk);
        inputs_quiet();
        #1;
        checks++; if (bus.bank_we !== 1'b1 || bus.bank_waddr !== 7'h21 || bus.bank_wdata !== 8'h02) begin errors++; $display("FAIL b2b_wr1 got %b/%h/%h want 1/21/02", bus.bank_we, bus.bank_waddr, bus.bank_wdata); end
        @(negedge clk);
        #1;
        checks++; if (bus.bank_we !== 1'b0) begin errors++; $display("FAIL b2b_wr_end got %b want 0", bus.bank_we); end
    endtask

    task automatic test_collision();
        @(negedge clk);
        bus.spi_cs_n = 1'b0;
        bus.spi_we = 1'b1; bus.spi_addr = 7'h02; bus.spi_wdata = 8'h11;
        bus.b_req = 1'b1; bus.b_wr = 1'b1; bus.b_addr = 7'h02; bus.b_wdata = 8'h22;
        #1;
        checks++; if (bus.b_ready !== 1'b0) begin errors++; $display("FAIL coll_ready got %b want 0", bus.b_ready); end
        @(negedge clk);
        bus.spi_we = 1'b0;
        #1;
        checks++; if (bus.b_ready !== 1'b1 || bus.bank_we !== 1'b1 || bus.bank_wdata !== 8'h11) begin errors++; $display("FAIL coll_spi_wr got %b %b/%h want 1 1/11", bus.b_ready, bus.bank_we, bus.bank_wdata); end
        checks++; if (bus.spi_status !== 8'hC0) begin errors++; $display("FAIL coll_status_t1 got %h want c0", bus.spi_status); end
        @(negedge clk);
        bus.b_req = 1'b0;
        #1;
        checks++; if (bus.bank_we !== 1'b1 || bus.bank_waddr !== 7'h02 || bus.bank_wdata !== 8'h22) begin errors++; $display("FAIL coll_b_wr got %b/%h/%h want 1/02/22", bus.bank_we, bus.bank_waddr, bus.bank_wdata); end
        checks++; if (bus.spi_status !== 8'h40) begin errors++; $display("FAIL coll_status_t2 got %h want 40", bus.spi_status); end
        @(negedge clk);
        bus.spi_cs_n = 1'b1;
        #1;
        checks++; if (bus.spi_status !== 8'h40) begin errors++; $display("FAIL coll_status_rise got %h want 40", bus.spi_status); end
        @(negedge clk);
        #1;
        checks++; if (bus.spi_status !== 8'h00) begin errors++; $display("FAIL coll_status_clear got %h want 00", bus.spi_status); end
        checks++; if (mem[2] !== 8'h22) begin errors++; $display("FAIL coll_bank_final got %h want 22", mem[2]); end
    endtask

    task automatic test_b_read_idle();
        @(negedge clk);
        bus.spi_cs_n = 1'b1; bus.spi_addr = 7'h05;
        bus.b_req = 1'b1; bus.b_wr = 1'b0; bus.b_addr = 7'h10;
        #1;
        checks++; if (bus.b_ready !== 1'b1 || bus.bank_raddr !== 7'h05) begin errors++; $display("FAIL rd_accept got %b@%h want 1@05", bus.b_ready, bus.bank_raddr); end
        @(negedge clk);
        inputs_quiet();
        #1;
        checks++; if (bus.bank_raddr !== 7'h10 || bus.b_ready !== 1'b0 || bus.b_rvalid !== 1'b0) begin errors++; $display("FAIL rd_brd got %h %b %b want 10 0 0", bus.bank_raddr, bus.b_ready, bus.b_rvalid); end
        checks++; if (bus.spi_status !== 8'h10) begin errors++; $display("FAIL rd_status got %h want 10", bus.spi_status); end
        @(negedge clk);
        #1;
        checks++; if (bus.b_rvalid !== 1'b1 || bus.b_rdata !== 8'h3C || bus.bank_raddr !== 7'h05) begin errors++; $display("FAIL rd_done got %b/%h@%h want 1/3c@05", bus.b_rvalid, bus.b_rdata, bus.bank_raddr); end
        @(negedge clk);
        #1;
        checks++; if (bus.b_rvalid !== 1'b0 || bus.b_rdata !== 8'h3C) begin errors++; $display("FAIL rd_after got %b/%h want 0/3c", bus.b_rvalid, bus.b_rdata); end
    endtask

    task automatic test_back_to_back_reads();
        logic [2:0] rdy;
        @(negedge clk);
        bus.b_req = 1'b1; bus.b_wr = 1'b0; bus.b_addr = 7'h07;
        #1; rdy[0] = bus.b_ready;
        @(negedge clk);
        #1; rdy[1] = bus.b_ready;
        @(negedge clk);
        bus.b_addr = 7'h10;
        #1; rdy[2] = bus.b_ready;
        checks++; if (rdy !== 3'b101 || bus.b_rvalid !== 1'b1 || bus.b_rdata !== 8'h5A) begin errors++; $display("FAIL rd_b2b got rdy=%b %b/%h want 101 1/5a", rdy, bus.b_rvalid, bus.b_rdata); end
        @(negedge clk);
        inputs_quiet();
        @(negedge clk);
        #1;
        checks++; if (bus.b_rvalid !== 1'b1 || bus.b_rdata !== 8'h3C) begin errors++; $display("FAIL rd_b2b_second got %b/%h want 1/3c", bus.b_rvalid, bus.b_rdata); end
    endtask

    task automatic test_timeout();
        int ready_seen = 0;
        logic [7:0] st254 = 8'h00;
        logic [7:0] st255 = 8'h00;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            bus.spi_cs_n = 1'b0;
            bus.b_req = 1'b1; bus.b_wr = 1'b0; bus.b_addr = 7'h05;
            #1;
            if (bus.b_ready) ready_seen++;
            if (i == 254) st254 = bus.spi_status;
            if (i == 255) st255 = bus.spi_status;
        end
        checks++; if (ready_seen !== 0) begin errors++; $display("FAIL to_ready_in_frame got %0d want 0", ready_seen); end
        checks++; if (st254 !== 8'h80) begin errors++; $display("FAIL to_status_254 got %h want 80", st254); end
        checks++; if (st255 !== 8'hA0) begin errors++; $display("FAIL to_status_255 got %h want a0", st255); end
        // cs rises during an SPI write strobe: still waiting, so set beats clear.
        @(negedge clk);
        bus.spi_cs_n = 1'b1; bus.spi_we = 1'b1; bus.spi_addr = 7'h30; bus.spi_wdata = 8'h77;
        #1;
        checks++; if (bus.b_ready !== 1'b0) begin errors++; $display("FAIL to_rise_we_ready got %b want 0", bus.b_ready); end
        @(negedge clk);
        bus.spi_we = 1'b0; bus.spi_addr = 7'h00;
        #1;
        checks++; if (bus.b_ready !== 1'b1 || bus.spi_status !== 8'hA0) begin errors++; $display("FAIL to_set_wins got %b/%h want 1/a0", bus.b_ready, bus.spi_status); end
        @(negedge clk);
        inputs_quiet();
        #1;
        checks++; if (bus.spi_status !== 8'h30) begin errors++; $display("FAIL to_brd_status got %h want 30", bus.spi_status); end
        @(negedge clk);
        #1;
        checks++; if (bus.b_rvalid !== 1'b1 || bus.b_rdata !== 8'hA5) begin errors++; $display("FAIL to_read_data got %b/%h want 1/a5", bus.b_rvalid, bus.b_rdata); end
        @(negedge clk);
        bus.spi_cs_n = 1'b0;
        @(negedge clk);
        bus.spi_cs_n = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus.spi_status !== 8'h00) begin errors++; $display("FAIL to_clear got %h want 00", bus.spi_status); end
    endtask

    task automatic test_ena();
        @(negedge clk);
        bus.spi_we = 1'b1; bus.spi_addr = 7'h31; bus.spi_wdata = 8'h99;
        @(negedge clk);
        bus.spi_we = 1'b0; ena = 1'b0;
        #1;
        checks++; if (bus.bank_we !== 1'b0) begin errors++; $display("FAIL ena_we_gate got %b want 0", bus.bank_we); end
        @(negedge clk);
        ena = 1'b1;
        #1;
        checks++; if (bus.bank_we !== 1'b1 || bus.bank_waddr !== 7'h31) begin errors++; $display("FAIL ena_we_resume got %b/%h want 1/31", bus.bank_we, bus.bank_waddr); end
        @(negedge clk);
        bus.b_req = 1'b1; bus.b_wr = 1'b0; bus.b_addr = 7'h10;
        @(negedge clk);
        inputs_quiet(); ena = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (bus.spi_status !== 8'h10 || bus.b_rvalid !== 1'b0 || bus.b_ready !== 1'b0) begin errors++; $display("FAIL ena_hold got %h %b %b want 10 0 0", bus.spi_status, bus.b_rvalid, bus.b_ready); end
        @(negedge clk);
        ena = 1'b1;
        #1;
        checks++; if (bus.spi_status !== 8'h10 || bus.b_rvalid !== 1'b0) begin errors++; $display("FAIL ena_complete_cycle got %h %b want 10 0", bus.spi_status, bus.b_rvalid); end
        @(negedge clk);
        #1;
        checks++; if (bus.b_rvalid !== 1'b1 || bus.b_rdata !== 8'h3C) begin errors++; $display("FAIL ena_rvalid got %b/%h want 1/3c", bus.b_rvalid, bus.b_rdata); end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        bus.b_req = 1'b1; bus.b_wr = 1'b0; bus.b_addr = 7'h10;
        @(negedge clk);
        inputs_quiet(); rstb = 1'b0;
        #1;
        checks++; if (bus.spi_status !== 8'h10) begin errors++; $display("FAIL rstrd_in_brd got %h want 10", bus.spi_status); end
        @(negedge clk);
        rstb = 1'b1;
        #1;
        checks++; if (bus.b_rvalid !== 1'b0 || bus.b_rdata !== 8'h00 || bus.spi_status !== 8'h00 || bus.b_ready !== 1'b1) begin errors++; $display("FAIL rstrd_after got %b/%h %h %b want 0/00 00 1", bus.b_rvalid, bus.b_rdata, bus.spi_status, bus.b_ready); end
        checks++; if (bus.bank_we !== 1'b0 || bus.bank_waddr !== 7'h00 || bus.bank_wdata !== 8'h00) begin errors++; $display("FAIL rstrd_wport got %b/%h/%h want 0/00/00", bus.bank_we, bus.bank_waddr, bus.bank_wdata); end
        @(negedge clk);
        #1;
        checks++; if (bus.b_rvalid !== 1'b0) begin errors++; $display("FAIL rstrd_no_rvalid got %b want 0", bus.b_rvalid); end
    endtask

    initial begin
        rstb = 1'b0;
        ena = 1'b1;
        bus.spi_cs_n = 1'b1;
        bus.spi_addr = '0;
        inputs_quiet();
        test_reset();
        test_spi_write();
        test_spi_read();
        test_back_to_back_writes();
        test_collision();
        test_b_read_idle();
        test_back_to_back_reads();
        test_timeout();
        test_ena();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_port_arbiter.md
# reg_port_arbiter

Shares one register bank between the SPI peripheral's application interface and a second on-chip requester (port B). The bank has one write port and one combinational read port. The block serialises writes, gives the SPI side absolute priority, and lends the read port to port B only outside SPI frames. It also generates the status byte that the SPI peripheral shifts out first in every frame.

## Interface

Parameters:
- REG_W, 8: data width; the address width is REG_W-1. Must be ≥ 4.
- TIMEOUT, 255: number of cycles a port-B request may wait before the timeout flag is set. Range 1..255.

Ports:
- clk  in  1  system clock.
- rstb  in  1  reset; synchronous, active-low.
- ena  in  1  global enable; when low, every register holds its value.
- spi_cs_n  in  1  SPI chip select, already synchronised to clk.
- spi_addr  in  REG_W-1  address from the SPI peripheral; held stable during a frame.
- spi_wdata  in  REG_W  write data from the SPI peripheral.
- spi_we  in  1  one-cycle write strobe from the SPI peripheral.
- spi_rdata  out  REG_W  read data to the SPI peripheral.
- spi_status  out  REG_W  status byte to the SPI peripheral.
- b_req  in  1  port-B request valid.
- b_wr  in  1  port-B direction: 1 = write, 0 = read.
- b_addr  in  REG_W-1  port-B address.
- b_wdata  in  REG_W  port-B write data.
- b_ready  out  1  port-B accept. A transfer completes in any cycle where b_req & b_ready.
- b_rvalid  out  1  one-cycle pulse: b_rdata is valid.
- b_rdata  out  REG_W  port-B read data.
- bank_we, bank_waddr, bank_wdata  out  1 / REG_W-1 / REG_W  bank write port.
- bank_raddr  out  REG_W-1  bank read address.
- bank_rdata  in  REG_W  bank read data; combinational from bank_raddr.

## Operation

State machine (2 states):
- IDLE → B_RD on an accepted port-B read.
- B_RD → IDLE unconditionally after 1 cycle.

Acceptance:
- b_ready = ena & (state == IDLE) & ~spi_we & (b_wr | spi_cs_n). This is combinational.
- Port-B reads are therefore only accepted while spi_cs_n is high.
- Port-B writes may be accepted during an SPI frame, except in a spi_we cycle.

Write path:
- The write port is registered. The winner in cycle t drives bank_we/bank_waddr/bank_wdata in cycle t+1.
- bank_we = we_q & ena.
- When spi_we is high, SPI wins. A simultaneous port-B write sees b_ready = 0 and retries. This sets the sticky collision bit.

Read path:
- bank_raddr = b_addr_q while in B_RD, otherwise spi_addr.
- spi_rdata = bank_rdata (combinational pass-through).
- In B_RD, bank_rdata is captured into b_rdata and b_rvalid is registered high.

Wait counter (8-bit, saturating):
- Increments while b_req & ~b_ready.
- Clears on an accept or when b_req is low.
- Reaching TIMEOUT sets the sticky timeout bit.

Status byte:
- spi_status = {b_req, coll_sticky, to_sticky, state == B_RD, (REG_W-4) zeros}.
- Sticky bits clear on the rising edge of spi_cs_n (cs_prev registered). If a set and a clear occur in the same cycle, the set wins.

## Timing

- Reset values: state IDLE, cs_prev 1, counter 0, sticky bits 0, we_q 0, b_rvalid 0, b_rdata 0, bank_waddr/bank_wdata 0.
- Reset-driven outputs: b_ready = spi_cs_n, spi_status = {b_req, 0, 0, 0, 0...}.
- Write latency: strobe or accept at cycle t → bank_we high for exactly cycle t+1.
- Read latency: accept at t → bank_raddr = b_addr in t+1 → b_rvalid and b_rdata in t+2 for one cycle.
- Throughput: back-to-back port-B writes run every cycle. Port-B reads run every 2 cycles (b_ready is low in B_RD).
- If spi_cs_n falls during B_RD, the read still completes. SPI needs more than 8 clk cycles before using rdata, so there is no conflict.
- If ena is low mid-B_RD, the state holds and the completion cycle is deferred.
- If rstb is asserted mid-transfer, the transfer is discarded: no bank_we and no b_rvalid after reset.

## Test plan

- SPI write: spi_we=1, spi_addr=0x05, spi_wdata=0xA5 at t → bank_we=1, bank_waddr=0x05, bank_wdata=0xA5 at t+1 only.
- Collision: spi_we=1 (addr 0x02, data 0x11) with b_req=1, b_wr=1 (addr 0x02, data 0x22) at t → b_ready=0 at t; SPI write at t+1; B write at t+2; spi_status[REG_W-2]=1 until the next rising edge of spi_cs_n.
- B read outside a frame: bank holds 0x3C at 0x10; b_req read, addr 0x10, spi_cs_n=1 → b_rvalid=1, b_rdata=0x3C two cycles after accept; bank_raddr=0x10 for 1 cycle, then back to spi_addr.
- B read during a frame: spi_cs_n=0 held for 300 cycles with b_req read pending → b_ready stays 0, to_sticky sets after 255 waiting cycles, and the read is accepted in the first cycle after spi_cs_n rises. The timeout bit clears on the edge where spi_cs_n rises unless it is set again in that same cycle.
- SPI read pass-through: spi_addr=0x07, bank[0x07]=0x5A, state IDLE → spi_rdata=0x5A in the same cycle.
- Reset mid-read: rstb low in B_RD → no b_rvalid; all outputs at their reset values on the next cycle.
